// File: rtl/avmm_mem_arbiter.sv
// avmm_mem_arbiter: two-master round-robin arbiter in front of one Avalon-MM burst slave.
// A write burst keeps the grant until its last beat is accepted. Each accepted read burst is
// tagged with its master id so in-order response beats are steered back to the issuer.
// Optional feature macro: AVMM_ARB_PERF_CNT_EN adds per-master grant and stall counters.
module avmm_mem_arbiter #(
    parameter int ADDR_W       = 26,
    parameter int DATA_W       = 512,
    parameter int BURST_W      = 7,
    parameter int RD_TAG_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [BURST_W-1:0]  m0_burstcount,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [BURST_W-1:0]  m1_burstcount,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic                s_read,
    output logic                s_write,
    output logic [ADDR_W-1:0]   s_address,
    output logic [BURST_W-1:0]  s_burstcount,
    output logic [DATA_W-1:0]   s_writedata,
    output logic [DATA_W/8-1:0] s_byteenable,
    input  logic                s_waitrequest,
    input  logic [DATA_W-1:0]   s_readdata,
    input  logic                s_readdatavalid,
    output logic                err_orphan_rsp
`ifdef AVMM_ARB_PERF_CNT_EN
    ,
    output logic [31:0]         m0_grant_cnt,
    output logic [31:0]         m1_grant_cnt,
    output logic [31:0]         m0_stall_cnt,
    output logic [31:0]         m1_stall_cnt
`endif
);

    localparam int PTR_W = $clog2(RD_TAG_DEPTH);
    localparam logic [BURST_W-1:0] BC_ONE  = BURST_W'(1);
    localparam logic [PTR_W:0]     PTR_ONE = (PTR_W+1)'(1);

    typedef enum logic {ST_IDLE, ST_WR_LOCK} state_t;

    state_t             r_state;
    logic               r_last_grant;
    logic               r_lock_id;
    logic [BURST_W-1:0] r_remaining;
    logic [BURST_W-1:0] r_beat_cnt;
    logic [PTR_W:0]     r_wr_ptr;
    logic [PTR_W:0]     r_rd_ptr;
    logic               r_tag_id [RD_TAG_DEPTH];
    logic [BURST_W-1:0] r_tag_bc [RD_TAG_DEPTH];
    logic               r_err_orphan;

    logic [1:0]          w_rd;
    logic [1:0]          w_wr;
    logic [ADDR_W-1:0]   w_addr [2];
    logic [BURST_W-1:0]  w_bc_raw [2];
    logic [BURST_W-1:0]  w_bc [2];
    logic [DATA_W-1:0]   w_wdata [2];
    logic [DATA_W/8-1:0] w_be [2];
    logic [1:0]          w_elig;
    logic                w_gnt_vld;
    logic                w_gnt_id;
    logic [1:0]          w_wait;
    logic                w_full;
    logic                w_empty;
    logic                w_accept;
    logic                w_push;
    logic                w_head_id;
    logic [BURST_W-1:0]  w_head_bc;
    logic                w_rsp_vld;
    logic [BURST_W-1:0]  w_beat_nxt;
    logic                w_pop;

    assign w_rd        = {m1_read, m0_read};
    assign w_wr        = {m1_write, m0_write};
    assign w_addr[0]   = m0_address;
    assign w_addr[1]   = m1_address;
    assign w_bc_raw[0] = m0_burstcount;
    assign w_bc_raw[1] = m1_burstcount;
    assign w_wdata[0]  = m0_writedata;
    assign w_wdata[1]  = m1_writedata;
    assign w_be[0]     = m0_byteenable;
    assign w_be[1]     = m1_byteenable;

    // Tag FIFO status from registered pointers (extra MSB distinguishes full from empty).
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                       (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_head_id = r_tag_id[r_rd_ptr[PTR_W-1:0]];
    assign w_head_bc = r_tag_bc[r_rd_ptr[PTR_W-1:0]];

    // A burstcount of zero means a single beat.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_bc[i] = (w_bc_raw[i] == '0) ? BC_ONE : w_bc_raw[i];
        end
    end

    // Pick the granted master: the lock owner during a write burst, else round-robin among eligible.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path can infer a latch.
        w_elig    = '0;
        w_gnt_vld = 1'b0;
        w_gnt_id  = 1'b0;
        if (r_state == ST_WR_LOCK) begin
            w_gnt_vld = 1'b1;
            w_gnt_id  = r_lock_id;
        end else begin
            w_elig[0] = w_wr[0] | (w_rd[0] & ~w_full);
            w_elig[1] = w_wr[1] | (w_rd[1] & ~w_full);
            if (&w_elig) begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = ~r_last_grant;
            end else if (w_elig[1]) begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = 1'b1;
            end else if (w_elig[0]) begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = 1'b0;
            end
        end
    end

    // Forward the granted command to the slave; everyone not being served sees waitrequest.
    always_comb begin
        s_read       = 1'b0;
        s_write      = 1'b0;
        s_address    = '0;
        s_burstcount = '0;
        s_writedata  = '0;
        s_byteenable = '0;
        w_wait       = 2'b11;
        if (reset_n && w_gnt_vld) begin
            s_write = w_wr[w_gnt_id];
            s_read  = (r_state == ST_IDLE) && w_rd[w_gnt_id] && !w_wr[w_gnt_id] && !w_full;
            if (s_read || s_write) begin
                s_address        = w_addr[w_gnt_id];
                s_burstcount     = w_bc_raw[w_gnt_id];
                s_writedata      = w_wdata[w_gnt_id];
                s_byteenable     = w_be[w_gnt_id];
                w_wait[w_gnt_id] = s_waitrequest;
            end
        end
    end

    assign m0_waitrequest = w_wait[0];
    assign m1_waitrequest = w_wait[1];

    assign w_accept   = (s_read | s_write) & ~s_waitrequest;
    assign w_push     = w_accept & s_read;
    assign w_rsp_vld  = s_readdatavalid & ~w_empty;
    assign w_beat_nxt = r_beat_cnt + BC_ONE;
    assign w_pop      = w_rsp_vld && (w_beat_nxt == w_head_bc);

    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;
    assign m0_readdatavalid = w_rsp_vld & ~w_head_id;
    assign m1_readdatavalid = w_rsp_vld & w_head_id;
    assign err_orphan_rsp   = r_err_orphan;

    // Arbitration state: round-robin history and the write-burst lock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_lock_id    <= 1'b0;
            r_remaining  <= '0;
        end else begin
            // NOTE: non-blocking so every register updates from the same pre-edge values.
            if (w_accept) r_last_grant <= w_gnt_id;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && s_write && (w_bc[w_gnt_id] != BC_ONE)) begin
                        r_state     <= ST_WR_LOCK;
                        r_lock_id   <= w_gnt_id;
                        r_remaining <= w_bc[w_gnt_id] - BC_ONE;
                    end
                end
                ST_WR_LOCK: begin
                    if (w_accept) begin
                        if (r_remaining == BC_ONE) r_state <= ST_IDLE;
                        r_remaining <= r_remaining - BC_ONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Tag FIFO pointers, response beat counter and the sticky orphan-response flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_beat_cnt   <= '0;
            r_err_orphan <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + PTR_ONE;
                r_beat_cnt <= '0;
            end else if (w_rsp_vld) begin
                r_beat_cnt <= w_beat_nxt;
            end
            if (s_readdatavalid && w_empty) r_err_orphan <= 1'b1;
        end
    end

    // Tag storage written on each accepted read burst.
    // NOTE: the storage array is not reset; only the pointers say which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_tag_id[r_wr_ptr[PTR_W-1:0]] <= w_gnt_id;
            r_tag_bc[r_wr_ptr[PTR_W-1:0]] <= w_bc[w_gnt_id];
        end
    end

`ifdef AVMM_ARB_PERF_CNT_EN
    logic [31:0] r_grant_cnt [2];
    logic [31:0] r_stall_cnt [2];

    // Count accepted commands (write burst starts, not beats) and stalled request cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                r_grant_cnt[i] <= '0;
                r_stall_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_accept && (r_state == ST_IDLE) && (w_gnt_id == 1'(i)))
                    r_grant_cnt[i] <= r_grant_cnt[i] + 32'd1;
                if ((w_rd[i] | w_wr[i]) & w_wait[i])
                    r_stall_cnt[i] <= r_stall_cnt[i] + 32'd1;
            end
        end
    end

    assign m0_grant_cnt = r_grant_cnt[0];
    assign m1_grant_cnt = r_grant_cnt[1];
    assign m0_stall_cnt = r_stall_cnt[0];
    assign m1_stall_cnt = r_stall_cnt[1];
`endif

endmodule
